// File: rtl/masked_sbox_arbiter.sv
// masked_sbox_arbiter: shares one pipelined masked AES S-box between the key schedule (port 0) and the round datapath (port 1)
//
// Ports (shares packed little-end first: share k occupies bits [8k+7:8k]):
//   in_clock                      rising-edge clock
//   in_reset                      synchronous active-low reset
//   in_req0_valid/_data/_tag      key-schedule request; out_req0_ready accepts it
//   in_req1_valid/_data/_tag      datapath request; out_req1_ready accepts it
//   out_sbox_a                    shares of the granted byte, all-zero without a grant
//   in_sbox_b                     shares returned by the S-box SBOX_LATENCY cycles later
//   out_rsp0_valid/out_rsp1_valid single-cycle result pulse for the owning port
//   out_rsp_data/out_rsp_tag      result shares and tag, zero when no result is valid
//   out_busy                      any request in flight
//
// Build option: define MASKED_SBOX_ARB_KEY_PRIO_EN for fixed port-0 priority
// (port 1 can starve); otherwise arbitration is round-robin.
module masked_sbox_arbiter #(
    parameter int NUM_SHARES   = 2,
    parameter int SBOX_LATENCY = 3,
    parameter int TAG_W        = 4
) (
    input  logic                    in_clock,
    input  logic                    in_reset,
    input  logic                    in_req0_valid,
    input  logic [8*NUM_SHARES-1:0] in_req0_data,
    input  logic [TAG_W-1:0]        in_req0_tag,
    output logic                    out_req0_ready,
    input  logic                    in_req1_valid,
    input  logic [8*NUM_SHARES-1:0] in_req1_data,
    input  logic [TAG_W-1:0]        in_req1_tag,
    output logic                    out_req1_ready,
    output logic [8*NUM_SHARES-1:0] out_sbox_a,
    input  logic [8*NUM_SHARES-1:0] in_sbox_b,
    output logic                    out_rsp0_valid,
    output logic                    out_rsp1_valid,
    output logic [8*NUM_SHARES-1:0] out_rsp_data,
    output logic [TAG_W-1:0]        out_rsp_tag,
    output logic                    out_busy
);
    localparam int LAST = SBOX_LATENCY - 1;

    if (SBOX_LATENCY < 1) begin : g_bad_latency
        $error("SBOX_LATENCY must be at least 1");
    end

    logic              grant0;
    logic              grant1;
    logic [LAST:0]     pipe_valid;
    logic [LAST:0]     pipe_port;
    logic [TAG_W-1:0]  pipe_tag [SBOX_LATENCY];
    logic              rsp_valid;

`ifdef MASKED_SBOX_ARB_KEY_PRIO_EN
    always_comb begin
        grant0 = in_reset && in_req0_valid;
        grant1 = in_reset && in_req1_valid && !in_req0_valid;
    end
`else
    // last_grant = 1 means port 1 was granted last, so port 0 wins the next contention
    logic last_grant;

    always_comb begin
        grant0 = in_reset && in_req0_valid && (!in_req1_valid || last_grant);
        grant1 = in_reset && in_req1_valid && (!in_req0_valid || !last_grant);
    end

    always_ff @(posedge in_clock) begin
        if (!in_reset)
            last_grant <= 1'b1;
        else if (grant0 || grant1)
            last_grant <= grant1;
    end
`endif

    // idle cycles present a zero sharing so stale shares never reach the S-box
    always_comb begin
        out_req0_ready = grant0;
        out_req1_ready = grant1;
        out_sbox_a     = grant0 ? in_req0_data : grant1 ? in_req1_data : '0;
    end

    // tracking pipe mirrors the S-box latency; reset drops everything in flight
    always_ff @(posedge in_clock) begin
        pipe_valid[0] <= in_reset && (grant0 || grant1);
        pipe_port[0]  <= grant1;
        pipe_tag[0]   <= grant0 ? in_req0_tag : grant1 ? in_req1_tag : '0;
        for (int i = 1; i < SBOX_LATENCY; i++) begin
            pipe_valid[i] <= in_reset && pipe_valid[i-1];
            pipe_port[i]  <= pipe_port[i-1];
            pipe_tag[i]   <= pipe_tag[i-1];
        end
    end

    always_comb begin
        rsp_valid      = pipe_valid[LAST];
        out_rsp0_valid = rsp_valid && !pipe_port[LAST];
        out_rsp1_valid = rsp_valid && pipe_port[LAST];
        out_rsp_tag    = rsp_valid ? pipe_tag[LAST] : '0;
        out_rsp_data   = rsp_valid ? in_sbox_b : '0;
        out_busy       = |pipe_valid;
    end
endmodule

// File: tb/tb_masked_sbox_arbiter.sv
// tb_masked_sbox_arbiter: randomized and directed check of masked_sbox_arbiter against a transaction-level model
module tb_masked_sbox_arbiter;
    localparam int L  = 3;
    localparam int TW = 4;

    typedef struct {
        int         due;
        logic       port;
        logic [3:0] tag;
        logic [7:0] x;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1;
    logic [15:0] d0, d1;
    logic [3:0]  t0, t1;
    logic        ready0, ready1;
    logic [15:0] sbox_a, sbox_b;
    logic        rsp0, rsp1;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        busy;
    logic [15:0] sb [L];
    logic [7:0]  mask;
    int          errors = 0;
    int          checks = 0;
    bit          started = 0;

    always #5 clk = ~clk;

    masked_sbox_arbiter #(.NUM_SHARES(2), .SBOX_LATENCY(L), .TAG_W(TW)) dut (
        .in_clock(clk), .in_reset(rst_n),
        .in_req0_valid(v0), .in_req0_data(d0), .in_req0_tag(t0), .out_req0_ready(ready0),
        .in_req1_valid(v1), .in_req1_data(d1), .in_req1_tag(t1), .out_req1_ready(ready1),
        .out_sbox_a(sbox_a), .in_sbox_b(sbox_b),
        .out_rsp0_valid(rsp0), .out_rsp1_valid(rsp1),
        .out_rsp_data(rsp_data), .out_rsp_tag(rsp_tag), .out_busy(busy)
    );

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
        end
        return p;
    endfunction

    // AES S-box from first principles: GF(2^8) inverse (x^254) then the affine map
    function automatic logic [7:0] aes_sbox(logic [7:0] x);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // environment S-box: fresh random output mask each cycle, fixed latency L
    always @(posedge clk) begin
        mask = 8'($urandom);
        sb[0] <= {mask, aes_sbox(sbox_a[7:0] ^ sbox_a[15:8]) ^ mask};
        for (int i = 1; i < L; i++) sb[i] <= sb[i-1];
    end
    assign sbox_b = sb[L-1];

    // reference model: accepted transactions queued with their due cycle
    item_t q[$];
    int    n = 0;
    bit    last = 1'b1;

    always @(negedge clk) begin
        if (started) begin
            bit         g0, g1, has_rsp;
            logic [15:0] exp_a;
            item_t      it;
            while (q.size() > 0 && q[0].due < n) void'(q.pop_front());
            has_rsp = q.size() > 0 && q[0].due == n;
`ifdef MASKED_SBOX_ARB_KEY_PRIO_EN
            g0 = rst_n && v0;
            g1 = rst_n && v1 && !v0;
`else
            g0 = rst_n && v0 && (!v1 || last);
            g1 = rst_n && v1 && !g0;
`endif
            exp_a = g0 ? d0 : g1 ? d1 : 16'h0;
            chk("ready0", 32'(ready0), 32'(g0));
            chk("ready1", 32'(ready1), 32'(g1));
            chk("sbox_a", 32'(sbox_a), 32'(exp_a));
            chk("rsp0_valid", 32'(rsp0), 32'(has_rsp && !q[0].port));
            chk("rsp1_valid", 32'(rsp1), 32'(has_rsp && q[0].port));
            chk("busy", 32'(busy), 32'(q.size() > 0));
            if (has_rsp) begin
                chk("rsp_tag", 32'(rsp_tag), 32'(q[0].tag));
                chk("rsp_xor", 32'(rsp_data[7:0] ^ rsp_data[15:8]), 32'(aes_sbox(q[0].x)));
            end else begin
                chk("rsp_data_zero", 32'(rsp_data), 32'h0);
            end
            if (!rst_n) begin
                q.delete();
                last = 1'b1;
            end else if (g0 || g1) begin
                it.due  = n + L;
                it.port = g1;
                it.tag  = g1 ? t1 : t0;
                it.x    = g1 ? (d1[7:0] ^ d1[15:8]) : (d0[7:0] ^ d0[15:8]);
                q.push_back(it);
                last = g1;
            end
            n++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v0 = 0; v1 = 0; d0 = '0; d1 = '0; t0 = '0; t1 = '0;
    endtask

    initial begin
        logic [7:0] m;
        rst_n = 0;
        idle();
        chk("sbox_53", 32'(aes_sbox(8'h53)), 32'hED);
        chk("sbox_00", 32'(aes_sbox(8'h00)), 32'h63);
        chk("sbox_01", 32'(aes_sbox(8'h01)), 32'h7C);
        chk("sbox_0f", 32'(aes_sbox(8'h0F)), 32'h76);
        tick();
        started = 1;
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rsp", 32'({rsp0, rsp1}), 32'h0);
        chk("rst_tag", 32'(rsp_tag), 32'h0);
        chk("rst_data", 32'(rsp_data), 32'h0);
        chk("rst_sbox_a", 32'(sbox_a), 32'h0);
        tick();
        // single accept: shares F6/A5 -> S(0x53) = 0xED after 3 cycles
        v0 = 1; d0 = {8'hA5, 8'hF6}; t0 = 4'h2;
        @(negedge clk);
        chk("single_ready0", 32'(ready0), 32'h1);
        tick();
        idle();
        tick();
        tick();
        @(negedge clk);
        chk("single_rsp0", 32'(rsp0), 32'h1);
        chk("single_tag", 32'(rsp_tag), 32'h2);
        chk("single_xor", 32'(rsp_data[7:0] ^ rsp_data[15:8]), 32'hED);
        tick();
        // back-to-back stream on port 1
        for (int i = 0; i < 16; i++) begin
            m = 8'($urandom);
            v1 = 1; d1 = {m, 8'(i) ^ m}; t1 = 4'(i);
            @(negedge clk);
            chk("stream_ready1", 32'(ready1), 32'h1);
            if (i >= L) chk("stream_rsp1", 32'(rsp1), 32'h1);
            tick();
        end
        idle();
        for (int i = 0; i < L + 1; i++) tick();
        // idle zeroing
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_sbox_a", 32'(sbox_a), 32'h0);
            chk("idle_rsp", 32'({rsp0, rsp1}), 32'h0);
            chk("idle_busy", 32'(busy), 32'h0);
            tick();
        end
        // reset mid-flight: two accepts, then a one-cycle reset drops them
        v0 = 1; d0 = 16'h1234; t0 = 4'h5;
        tick();
        d0 = 16'h5678; t0 = 4'h6;
        tick();
        idle();
        v1 = 1; d1 = 16'h00FF;
        rst_n = 0;
        @(negedge clk);
        chk("rst_hold_ready1", 32'(ready1), 32'h0);
        tick();
        rst_n = 1;
        idle();
        for (int i = 0; i < L + 2; i++) begin
            @(negedge clk);
            chk("drop_rsp", 32'({rsp0, rsp1}), 32'h0);
            chk("drop_busy", 32'(busy), 32'h0);
            tick();
        end
        // contention: port 0 byte 0x01 tags 8..11, port 1 byte 0x00 tags 0..3
        for (int i = 0; i < 4; i++) begin
            v0 = 1; d0 = 16'h0001; t0 = 4'(8 + i);
            v1 = 1; d1 = 16'h0000; t1 = 4'(i);
            @(negedge clk);
`ifdef MASKED_SBOX_ARB_KEY_PRIO_EN
            chk("cont_ready0", 32'(ready0), 32'h1);
`else
            chk("cont_ready0", 32'(ready0), 32'(i % 2 == 0));
`endif
            tick();
        end
        v0 = 0;
        @(negedge clk);
        chk("cont_tail_ready1", 32'(ready1), 32'h1);
        tick();
        idle();
        for (int i = 0; i < L + 1; i++) tick();
        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            d0 = 16'($urandom); d1 = 16'($urandom);
            t0 = 4'($urandom); t1 = 4'($urandom);
            rst_n = $urandom_range(0, 63) != 0;
            tick();
        end
        idle();
        rst_n = 1;
        for (int i = 0; i < L + 2; i++) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
